// File: rtl/branch_pkg.sv
// ============================================================================
// Module : branch_pkg
// Brief  : Shared constants, encodings and decode helper for the branch
//          sequencer: opcodes, state/class enums, Psel codes, field offsets.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package branch_pkg;

    localparam int CW_WIDTH = 31;

    // Control word field offsets, LSB first
    localparam int OFS_SL     = 0;
    localparam int OFS_PCSEL  = 1;
    localparam int OFS_BSEL   = 2;
    localparam int OFS_EN_PC  = 3;
    localparam int OFS_EN_B   = 4;
    localparam int OFS_EN_ALU = 5;
    localparam int OFS_EN_MEM = 6;
    localparam int OFS_RAMW   = 7;
    localparam int OFS_REGW   = 8;
    localparam int OFS_FSEL   = 9;
    localparam int OFS_SB     = 14;
    localparam int OFS_SA     = 19;
    localparam int OFS_DA     = 24;
    localparam int OFS_PSEL   = 29;

    localparam logic [1:0] PSEL_HOLD = 2'b00;
    localparam logic [1:0] PSEL_INC4 = 2'b01;
    localparam logic [1:0] PSEL_ABUS = 2'b10;
    localparam logic [1:0] PSEL_REL  = 2'b11;

    localparam logic [4:0] FSEL_OR = 5'b00100;

    localparam logic [5:0]  OPC_B     = 6'b000101;
    localparam logic [5:0]  OPC_BL    = 6'b100101;
    localparam logic [7:0]  OPC_BCOND = 8'b01010100;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;
    localparam logic [21:0] OPC_BR    = 22'b1101011000011111000000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LINK = 3'd1,
        ST_TEST = 3'd2,
        ST_EXEC = 3'd3,
        ST_ILL  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_B     = 3'd0,
        CLS_BL    = 3'd1,
        CLS_BCOND = 3'd2,
        CLS_CB    = 3'd3,
        CLS_BR    = 3'd4,
        CLS_ILL   = 3'd5
    } class_t;

    // NOP: PC hold, all register selects parked on the zero register
    function automatic logic [CW_WIDTH-1:0] make_nop(input logic [4:0] zero_reg);
        logic [CW_WIDTH-1:0] cw;
        cw = '0;
        cw[OFS_DA +: 5] = zero_reg;
        cw[OFS_SA +: 5] = zero_reg;
        cw[OFS_SB +: 5] = zero_reg;
        return cw;
    endfunction

    localparam logic [CW_WIDTH-1:0] CW_NOP = make_nop(5'd31);

    function automatic class_t decode_class(input logic [31:0] ins);
        class_t c;
        c = CLS_ILL;
        if (ins[31:26] == OPC_B) begin
            c = CLS_B;
        end else if (ins[31:26] == OPC_BL) begin
            c = CLS_BL;
        end else if (ins[31:24] == OPC_BCOND) begin
            c = CLS_BCOND;
        end else if ((ins[31:24] == OPC_CBZ) || (ins[31:24] == OPC_CBNZ)) begin
            c = CLS_CB;
        end else if ((ins[31:10] == OPC_BR) && (ins[4:0] == 5'd0)) begin
            c = CLS_BR;
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond_eval.sv
// ============================================================================
// Module : branch_cond_eval
// Brief  : Combinational ARMv8 condition-code evaluator, status = {V,C,Z,N}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_cond_eval (
    input  logic [3:0] i_cond,
    input  logic [3:0] i_status,
    output logic       o_cond_true
);

    logic w_v;
    logic w_c;
    logic w_z;
    logic w_n;
    logic w_base;

    assign w_v = i_status[3];
    assign w_c = i_status[2];
    assign w_z = i_status[1];
    assign w_n = i_status[0];

    always_comb begin
        w_base = 1'b1;
        case (i_cond[3:1])
            3'b000:  w_base = w_z;
            3'b001:  w_base = w_c;
            3'b010:  w_base = w_n;
            3'b011:  w_base = w_v;
            3'b100:  w_base = w_c & ~w_z;
            3'b101:  w_base = (w_n == w_v);
            3'b110:  w_base = ~w_z & (w_n == w_v);
            default: w_base = 1'b1;
        endcase
    end

    // NV (1111) is architecturally "always", so it escapes the inversion
    assign o_cond_true = (i_cond[0] && (i_cond != 4'b1111)) ? ~w_base : w_base;

endmodule

`default_nettype wire

// File: rtl/branch_sequencer.sv
// ============================================================================
// Module : branch_sequencer
// Brief  : Multi-cycle control unit for B, BL, B.cond, CBZ, CBNZ and BR.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_sequencer
    import branch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter logic [4:0]  LINK_REG     = 5'd30,
    parameter logic [4:0]  ZERO_REG     = 5'd31,
    parameter bit          ENABLE_BCOND = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           instruction,
    input  logic [3:0]            status,
    output logic [CW_WIDTH-1:0]   control_word,
    output logic [DATA_WIDTH-1:0] K,
    output logic                  busy,
    output logic                  done,
    output logic                  taken,
    output logic                  illegal
);

    state_t r_state;
    state_t w_next;

    logic [31:0] r_instr;
    logic [3:0]  r_status;

    class_t w_cls_in;
    class_t w_cls;
    logic   w_cond_true;

    logic [CW_WIDTH-1:0]   w_cw;
    logic [DATA_WIDTH-1:0] w_k;
    logic                  w_done;
    logic                  w_taken;
    logic                  w_illegal;

    always_comb begin
        w_cls_in = decode_class(instruction);
        if (!ENABLE_BCOND && (w_cls_in == CLS_BCOND)) begin
            w_cls_in = CLS_ILL;
        end
        w_cls = decode_class(r_instr);
        if (!ENABLE_BCOND && (w_cls == CLS_BCOND)) begin
            w_cls = CLS_ILL;
        end
    end

    generate
        if (ENABLE_BCOND) begin : g_bcond
            branch_cond_eval u_cond_eval (
                .i_cond      (r_instr[3:0]),
                .i_status    (r_status),
                .o_cond_true (w_cond_true)
            );
        end else begin : g_no_bcond
            assign w_cond_true = 1'b0;
        end
    endgenerate

    // State, instruction latch and the status snapshot used by B.cond
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_instr  <= '0;
            r_status <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && start) begin
                r_instr  <= instruction;
                r_status <= status;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (w_cls_in)
                        CLS_BL:  w_next = ST_LINK;
                        CLS_CB:  w_next = ST_TEST;
                        CLS_ILL: w_next = ST_ILL;
                        default: w_next = ST_EXEC;
                    endcase
                end
            end
            ST_LINK: w_next = ST_EXEC;
            ST_TEST: w_next = ST_EXEC;
            ST_EXEC: w_next = ST_IDLE;
            ST_ILL:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cw      = make_nop(ZERO_REG);
        w_done    = 1'b0;
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (r_state)
            ST_LINK: begin
                w_cw[OFS_DA +: 5] = LINK_REG;
                w_cw[OFS_EN_PC]   = 1'b1;
                w_cw[OFS_REGW]    = 1'b1;
            end
            ST_TEST: begin
                // OR Rt with zero purely to refresh Z in the status register
                w_cw[OFS_SA +: 5]   = ZERO_REG;
                w_cw[OFS_SB +: 5]   = r_instr[4:0];
                w_cw[OFS_FSEL +: 5] = FSEL_OR;
                w_cw[OFS_SL]        = 1'b1;
            end
            ST_EXEC: begin
                w_cw[OFS_PCSEL] = 1'b1;
                w_done          = 1'b1;
                case (w_cls)
                    CLS_B, CLS_BL: w_cw[OFS_PSEL +: 2] = PSEL_REL;
                    CLS_BR: begin
                        w_cw[OFS_SA +: 5]   = r_instr[9:5];
                        w_cw[OFS_PSEL +: 2] = PSEL_ABUS;
                    end
                    CLS_BCOND: w_cw[OFS_PSEL +: 2] = w_cond_true ? PSEL_REL : PSEL_INC4;
                    // Live Z: TEST has just reloaded status from Rt
                    CLS_CB:    w_cw[OFS_PSEL +: 2] = {status[1] ^ r_instr[24], 1'b1};
                    default:   w_cw[OFS_PSEL +: 2] = PSEL_INC4;
                endcase
                w_taken = w_cw[OFS_PSEL + 1];
            end
            ST_ILL: begin
                w_cw[OFS_PSEL +: 2] = PSEL_INC4;
                w_illegal           = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_k = '0;
        case (w_cls)
            CLS_B, CLS_BL:     w_k = {{(DATA_WIDTH-26){r_instr[25]}}, r_instr[25:0]};
            CLS_BCOND, CLS_CB: w_k = {{(DATA_WIDTH-19){r_instr[23]}}, r_instr[23:5]};
            default:           w_k = '0;
        endcase
    end

    assign control_word = w_cw;
    assign K            = w_k;
    assign busy         = (r_state != ST_IDLE);
    assign done         = w_done;
    assign taken        = w_taken;
    assign illegal      = w_illegal;

endmodule

`default_nettype wire

// File: tb/tb_branch_sequencer.sv
// ============================================================================
// Module : tb_branch_sequencer
// Brief  : Directed, table-driven self-checking bench for branch_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] instruction;
    logic [3:0]  status;
    logic [30:0] control_word;
    logic [63:0] K;
    logic        busy;
    logic        done;
    logic        taken;
    logic        illegal;

    int n_checks = 0;
    int n_err    = 0;

    branch_sequencer #(
        .DATA_WIDTH   (64),
        .LINK_REG     (5'd30),
        .ZERO_REG     (5'd31),
        .ENABLE_BCOND (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .instruction  (instruction),
        .status       (status),
        .control_word (control_word),
        .K            (K),
        .busy         (busy),
        .done         (done),
        .taken        (taken),
        .illegal      (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pack fields in decoder order; ramW, EN_MEM, EN_ALU, EN_B, Bsel are never set
    function automatic logic [30:0] mk_cw(input logic [1:0] psel, input logic [4:0] da,
                                          input logic [4:0] sa, input logic [4:0] sb,
                                          input logic [4:0] fsel, input logic regw,
                                          input logic enpc, input logic pcsel, input logic sl);
        return {psel, da, sa, sb, fsel, regw, 1'b0, 1'b0, 1'b0, 1'b0, enpc, 1'b0, pcsel, sl};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  st0;
        logic [3:0]  st1;
        int          lat;
        logic [30:0] cw1;
        logic [30:0] cwx;
        logic [63:0] k;
        bit          kv;
        bit          tk;
        bit          il;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];

    logic [30:0] nop_cw;
    logic [30:0] link_cw;
    logic [30:0] rel_cw;
    logic [30:0] inc_cw;
    logic [30:0] ill_cw;
    logic [30:0] test3_cw;

    initial begin
        nop_cw   = mk_cw(2'b00, 5'd31, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        link_cw  = mk_cw(2'b00, 5'd30, 5'd31, 5'd31, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        rel_cw   = mk_cw(2'b11, 5'd31, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        inc_cw   = mk_cw(2'b01, 5'd31, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        ill_cw   = mk_cw(2'b01, 5'd31, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test3_cw = mk_cw(2'b00, 5'd31, 5'd31, 5'd3, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b1);

        //        name        instr         st0      st1      lat cw1       cwx      K                      kv tk il
        vt[0]  = '{"B_m1",    32'h17FFFFFF, 4'b0000, 4'b0000, 1, nop_cw,   rel_cw, 64'hFFFFFFFFFFFFFFFF, 1, 1, 0};
        vt[1]  = '{"BL",      32'h94000010, 4'b0000, 4'b0000, 2, link_cw,  rel_cw, 64'h10,               1, 1, 0};
        vt[2]  = '{"CBZ_z1",  32'hB4000083, 4'b0000, 4'b0010, 2, test3_cw, rel_cw, 64'h4,                1, 1, 0};
        vt[3]  = '{"CBNZ_z1", 32'hB5000083, 4'b0000, 4'b0010, 2, test3_cw, inc_cw, 64'h4,                1, 0, 0};
        vt[4]  = '{"CBNZ_z0", 32'hB5000083, 4'b0010, 4'b0000, 2, test3_cw, rel_cw, 64'h4,                1, 1, 0};
        vt[5]  = '{"BNE_z0",  32'h54000041, 4'b0000, 4'b0010, 1, nop_cw,   rel_cw, 64'h2,                1, 1, 0};
        vt[6]  = '{"BNE_z1",  32'h54000041, 4'b0010, 4'b0000, 1, nop_cw,   inc_cw, 64'h2,                1, 0, 0};
        vt[7]  = '{"BAL",     32'h5400004E, 4'b0000, 4'b0000, 1, nop_cw,   rel_cw, 64'h2,                1, 1, 0};
        vt[8]  = '{"BNV",     32'h5400004F, 4'b1111, 4'b0000, 1, nop_cw,   rel_cw, 64'h2,                1, 1, 0};
        vt[9]  = '{"BGE_nv",  32'h5400004A, 4'b0001, 4'b1001, 1, nop_cw,   inc_cw, 64'h2,                1, 0, 0};
        vt[10] = '{"BHI_c",   32'h54000048, 4'b0100, 4'b0010, 1, nop_cw,   rel_cw, 64'h2,                1, 1, 0};
        vt[11] = '{"BR_x7",   32'hD61F00E0, 4'b0000, 4'b0000, 1, nop_cw,
                   mk_cw(2'b10, 5'd31, 5'd7, 5'd31, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), 64'h0, 0, 1, 0};
        vt[12] = '{"ILL_0",   32'h00000000, 4'b0000, 4'b0000, 1, nop_cw,   ill_cw, 64'h0,                0, 0, 1};
        vt[13] = '{"BR_bad",  32'hD61F00E1, 4'b0000, 4'b0000, 1, nop_cw,   ill_cw, 64'h0,                0, 0, 1};
        vt[14] = '{"BEQ_m1",  32'h54FFFFE0, 4'b0010, 4'b0000, 1, nop_cw,   rel_cw, 64'hFFFFFFFFFFFFFFFF, 1, 1, 0};

        reset       = 1'b0;
        start       = 1'b0;
        instruction = 32'h0;
        status      = 4'h0;
        repeat (2) tick();
        chk("rst_cw", {33'd0, control_word}, {33'd0, nop_cw});
        chk("rst_K", K, 64'h0);
        chk("rst_flags", {60'd0, busy, done, taken, illegal}, 64'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            start       = 1'b1;
            instruction = vt[i].instr;
            status      = vt[i].st0;
            tick();
            start       = 1'b0;
            instruction = 32'hDEADBEEF;
            status      = vt[i].st1;
            if (vt[i].lat == 2) begin
                chk({vt[i].name, "_cw1"}, {33'd0, control_word}, {33'd0, vt[i].cw1});
                chk({vt[i].name, "_busy1"}, {62'd0, busy, done}, {62'd0, 1'b1, 1'b0});
                tick();
            end
            chk({vt[i].name, "_cwx"}, {33'd0, control_word}, {33'd0, vt[i].cwx});
            chk({vt[i].name, "_flags"}, {60'd0, busy, done, taken, illegal},
                {60'd0, 1'b1, ~vt[i].il, vt[i].tk, vt[i].il});
            if (vt[i].kv) chk({vt[i].name, "_K"}, K, vt[i].k);
            tick();
            chk({vt[i].name, "_idle"}, {31'd0, busy, done, control_word},
                {31'd0, 1'b0, 1'b0, nop_cw});
        end

        // Start held through a BL with a different instruction presented mid-sequence
        start       = 1'b1;
        instruction = 32'h94000010;
        status      = 4'h0;
        tick();
        instruction = 32'h17FFFFFF;
        chk("hold_link", {33'd0, control_word}, {33'd0, link_cw});
        tick();
        chk("hold_exec_K", K, 64'h10);
        chk("hold_exec_done", {62'd0, done, taken}, {62'd0, 1'b1, 1'b1});
        tick();
        chk("hold_idle", {62'd0, busy, done}, 64'h0);
        tick();
        start = 1'b0;
        chk("hold_b_exec", {32'd0, done, control_word}, {32'd0, 1'b1, rel_cw});
        chk("hold_b_K", K, 64'hFFFFFFFFFFFFFFFF);
        tick();
        chk("hold_end", {62'd0, busy, done}, 64'h0);

        // Reset asserted while in TEST aborts the CBZ
        start       = 1'b1;
        instruction = 32'hB4000083;
        status      = 4'b0010;
        tick();
        start = 1'b0;
        chk("abort_test", {33'd0, control_word}, {33'd0, test3_cw});
        reset = 1'b0;
        tick();
        chk("abort_nop", {31'd0, busy, done, control_word}, {31'd0, 1'b0, 1'b0, nop_cw});
        reset = 1'b1;
        tick();
        chk("abort_quiet", {60'd0, busy, done, taken, illegal}, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
